simon_pad: RTL

//  Player-side front end of the Simon game: the other end of the Simon core's

---
 rtl/simon_pkg.sv | 27 ++
 rtl/btn_sync.sv | 24 ++
 rtl/simon_pad.sv | 135 +++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared types and small helpers for the Simon player pad.
package simon_pkg;

   localparam int NUM_BTN = 4;

   typedef enum logic [1:0] {IDLE, DEBOUNCE, RELEASE} pad_state_t;

   // Number 0..3 to its LED/button bit.
   function automatic logic [3:0] onehot2(input logic [1:0] n);
      return 4'b0001 << n;
   endfunction

   // Button bit to number; only meaningful for one-hot inputs.
   function automatic logic [1:0] enc4(input logic [3:0] v);
      case (v)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
   endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser bringing the raw push-buttons into the clk domain.
module btn_sync
   import simon_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btnRaw,
   output logic [NUM_BTN-1:0] btnSync
);

   logic [NUM_BTN-1:0] meta;

   // NOTE: non-blocking assignments keep the two stages a true shift; blocking would collapse them into one flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta    <= '0;
         btnSync <= '0;
      end else begin
         meta    <= btnRaw;
         btnSync <= meta;
      end
   end

endmodule

// File: rtl/simon_pad.sv
// Player-side pad for the Simon core: debounced one-pulse-per-press button
// decoding plus the LED driver for Simon's turn, player feedback and game over.
module simon_pad
   import simon_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 3,
   parameter int BLINK_TICKS    = 30
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn,
   input  logic               simonTurn,
   input  logic [1:0]         simonNum,
   input  logic               simonPressed,
   input  logic               gameOver,
   output logic [1:0]         playerNum,
   output logic               playerPressed,
   output logic               invalidPress,
   output logic [NUM_BTN-1:0] led
);

   localparam int DB_W = $clog2(DEBOUNCE_TICKS) + 1;
   localparam int BL_W = $clog2(BLINK_TICKS) + 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);
   localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_TICKS - 1);

   pad_state_t         state;
   logic [NUM_BTN-1:0] s;
   logic [NUM_BTN-1:0] cap;
   logic [DB_W-1:0]    cnt;
   logic               lit;
   logic [BL_W-1:0]    blinkCnt;
   logic               blinkPhase;

   btn_sync uSync (
      .clk    (clk),
      .reset  (reset),
      .btnRaw (btn),
      .btnSync(s)
   );

   // Next-cycle view of the player feedback so the LED lights in the same
   // cycle as the playerPressed pulse and goes dark as RELEASE exits.
   logic       acceptNow;
   logic       releaseDone;
   logic       showNext;
   logic [1:0] numNext;

   assign acceptNow   = (state == DEBOUNCE) && (s == cap) && !simonTurn && !gameOver
                        && (cnt == DB_LAST) && is_onehot4(cap);
   assign releaseDone = (state == RELEASE) && (s == '0) && (cnt == DB_LAST);
   assign showNext    = acceptNow || (lit && !releaseDone);
   assign numNext     = acceptNow ? enc4(cap) : playerNum;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cap           <= '0;
         cnt           <= '0;
         lit           <= 1'b0;
         playerNum     <= 2'd0;
         playerPressed <= 1'b0;
         invalidPress  <= 1'b0;
      end else begin
         playerPressed <= 1'b0;
         invalidPress  <= 1'b0;
         playerNum     <= numNext;
         lit           <= showNext;
         case (state)
            IDLE: begin
               if (s != '0 && !simonTurn && !gameOver) begin
                  state <= DEBOUNCE;
                  cap   <= s;
                  cnt   <= '0;
               end
            end
            DEBOUNCE: begin
               if (s != cap) begin
                  state <= IDLE;
               end else if (simonTurn || gameOver) begin
                  state <= RELEASE;
                  cnt   <= '0;
               end else if (cnt == DB_LAST) begin
                  playerPressed <= is_onehot4(cap);
                  invalidPress  <= !is_onehot4(cap);
                  state         <= RELEASE;
                  cnt           <= '0;
               end else begin
                  cnt <= cnt + DB_W'(1);
               end
            end
            RELEASE: begin
               // Any bounce back to pressed restarts the release window.
               if (s != '0) begin
                  cnt <= '0;
               end else if (cnt == DB_LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + DB_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blinkCnt   <= '0;
         blinkPhase <= 1'b0;
         led        <= '0;
      end else begin
         if (!gameOver) begin
            blinkCnt   <= '0;
            blinkPhase <= 1'b0;
         end else if (blinkCnt == BL_LAST) begin
            blinkCnt   <= '0;
            blinkPhase <= ~blinkPhase;
         end else begin
            blinkCnt <= blinkCnt + BL_W'(1);
         end

         if (gameOver)
            led <= {NUM_BTN{blinkPhase}};
         else if (simonTurn)
            led <= simonPressed ? onehot2(simonNum) : '0;
         else if (showNext)
            led <= onehot2(numNext);
         else
            led <= '0;
      end
   end

endmodule
